// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV/DIVU
//
// Purpose: multi-cycle signed/unsigned divider producing {HI=remainder, LO=quotient}.
//   One restoring step per cycle on a 2*WIDTH partial-remainder register,
//   then a sign fix-up for signed operation.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-low reset
//   start      - divide requested by the instruction in E (held while stalled)
//   signed_div - 1 = DIV, 0 = DIVU; sampled with start
//   a, b       - dividend / divisor; sampled with start
//   annul      - cancel the current operation
//   stall_div  - stall request to the hazard unit
//   ready      - one-cycle pulse, result valid this cycle
//   result     - {HI = remainder, LO = quotient}
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] rem;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_q, neg_r;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] rem_step;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               last;
  logic               launch;

  always_comb begin
    a_neg  = signed_div & a[WIDTH-1];
    b_neg  = signed_div & b[WIDTH-1];
    a_abs  = a_neg ? -a : a;
    b_abs  = b_neg ? -b : b;
    launch = (state == IDLE) & start & ~annul;
    // The bit shifted out of the upper half is kept as a carry: the shifted
    // remainder can need WIDTH+1 bits when the divisor is >= 2^(WIDTH-1).
    trial  = rem[2*WIDTH-1:WIDTH-1] - {1'b0, dvsr};
    if (!trial[WIDTH])
      rem_step = {trial[WIDTH-1:0], rem[WIDTH-2:0], 1'b1};
    else
      rem_step = {rem[2*WIDTH-2:0], 1'b0};
    q_fix = neg_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
    r_fix = neg_r ? -rem_step[2*WIDTH-1:WIDTH] : rem_step[2*WIDTH-1:WIDTH];
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (launch) state_nx = (b == '0) ? DONE : RUN;
      RUN:  if (annul) state_nx = IDLE;
            else if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // annul drops the stall in the same cycle so the flush can proceed.
  assign stall_div = ~annul & (((state == IDLE) & start) | (state == RUN));
  assign ready     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (launch) begin
            if (b != '0) begin
              rem   <= {{WIDTH{1'b0}}, a_abs};
              dvsr  <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= '0;
            end else begin
              result <= {a, {WIDTH{1'b1}}};
            end
          end
        end
        RUN: begin
          if (!annul) begin
            rem <= rem_step;
            cnt <= cnt + 1'b1;
            if (last) result <= {r_fix, q_fix};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .annul(annul), .stall_div(stall_div), .ready(ready),
    .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Launches one divide in the next cycle, holds start until ready, and
  // checks stall pattern, latency and the scoreboarded result.
  task automatic do_div(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm, output int rcyc);
    int   lat;
    int   got;
    int   stall_bad;
    exp_t e;
    lat = (bv == 32'd0) ? 1 : 33;
    got = -1;
    stall_bad = 0;
    rcyc = -1;
    @(posedge clk); #1;
    start = 1'b1; signed_div = sg; a = av; b = bv;
    sb.push_back('{ehi, elo});
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (stall_div !== (k < lat)) stall_bad++;
      if (ready === 1'b1) begin
        got  = k;
        rcyc = cyc;
        break;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        a = ~av; b = bv ^ 32'h5a5a_1234; signed_div = ~sg;
      end
    end
    check({nm, "_latency"}, 64'(got), 64'(lat));
    check({nm, "_stall"}, 64'(stall_bad), 64'd0);
    if (got >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      check({nm, "_result"}, result, {e.hi, e.lo});
    end else begin
      void'(sb.pop_front());
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", nm);
    end
  endtask

  initial begin
    int          r1, r2, c0, bad;
    logic        sg;
    logic [31:0] av, bv, ehi, elo;
    logic signed [31:0] sa, sbv;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000};
    vecs[3]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  32'd1};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd3};
    vecs[9]  = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF};
    vecs[11] = '{1'b0, 32'h1234_5678,  32'h100,        32'h78,         32'h0012_3456};

    rst = 1'b0; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", 64'(stall_div), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i])
      do_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             $sformatf("vec%0d", i), r1);

    for (int i = 0; i < 6; i++) begin
      sg = i[0];
      av = $urandom;
      bv = $urandom >> $urandom_range(0, 28);
      if (bv == 32'd0) bv = 32'd1;
      if (sg && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) bv = 32'd3;
      if (sg) begin
        sa = av; sbv = bv;
        elo = sa / sbv;
        ehi = sa % sbv;
      end else begin
        elo = av / bv;
        ehi = av % bv;
      end
      do_div(sg, av, bv, ehi, elo, $sformatf("rnd%0d", i), r1);
    end

    // Annul mid-run, then a fresh divide from cycle 12.
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
    bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall_drop", 64'(stall_div), 64'd0);
    check("annul_no_ready_run", 64'(bad + int'(ready)), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    @(negedge clk);
    check("annul_idle_ready", 64'(ready), 64'd0);
    check("annul_idle_stall", 64'(stall_div), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, "after_annul", r1);
    check("after_annul_cycle", 64'(r1 - c0), 64'd45);

    // Reset in cycle 5 of a run.
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; a = 32'h0000_FFFF; b = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("rst_sync_stall", 64'(stall_div), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_stall", 64'(stall_div), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Back-to-back with start held through DONE.
    do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_first", r1);
    do_div(1'b0, 32'h1000, 32'h10, 32'd0, 32'h100, "b2b_second", r2);
    check("b2b_spacing", 64'(r2 - r1), 64'd34);
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0 || stall_div !== 1'b0) bad++;
    end
    check("b2b_no_extra_ready", 64'(bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
